// File: rtl/uart_tx_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl_pkg
//   Shared definitions for the CPU serial-output path: MMIO addresses used by
//   the CPU address decoder to produce wr_en / clr_ovf, the default bit
//   period, and the transmit FSM state type.
// ---------------------------------------------------------------------------
package uart_tx_ctrl_pkg;

    // MMIO map decoded by the CPU load/store unit
    localparam logic [31:0] UART_DATA_ADDR = 32'h1000_0000;
    localparam logic [31:0] UART_STAT_ADDR = 32'h1000_0004;

    // 10 MHz sysclk / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 87;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl_if
//   CPU-side register interface of the UART transmitter.
//   master (CPU) drives : wr_en, wr_data, clr_ovf
//   slave  (UART) drives: full, level, busy, ovf
// ---------------------------------------------------------------------------
interface uart_tx_ctrl_if #(
    parameter int PTR_W = 4
) ();
    import uart_tx_ctrl_pkg::*;

    logic             wr_en;    // store to the data address this cycle
    logic [7:0]       wr_data;  // byte to transmit
    logic             clr_ovf;  // store to the status address
    logic             full;     // FIFO holds FIFO_DEPTH bytes
    logic [PTR_W:0]   level;    // FIFO occupancy
    logic             busy;     // FIFO non-empty or frame in progress
    logic             ovf;      // sticky dropped-write flag

    modport master (
        output wr_en, wr_data, clr_ovf,
        input  full, level, busy, ovf
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf,
        output full, level, busy, ovf
    );

endinterface

// File: rtl/uart_tx_ctrl_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with registered occupancy count.
//   clk, rst_n        : clock, async active-low reset (empties the FIFO)
//   push, push_data   : write request (ignored while full)
//   pop, pop_data     : read request (ignored while empty); pop_data shows
//                       the head entry combinationally
//   full, empty, level: status decoded from the registered count
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == (PTR_W+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign pop_data = mem_q[rptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push_ok) wptr_d = wptr_q + PTR_W'(1);
        if (pop_ok)  rptr_d = rptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (PTR_W+1)'(1);
            2'b01:   level_d = level_q - (PTR_W+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: entries are only read after being written
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//   Drains the CPU's UART byte FIFO into 8N1 frames (idle high, LSB first).
//   sysclk      : system clock, rising edge
//   cpu_resetn  : async active-low reset; aborts any frame, line goes high
//   bus (slave) : wr_en/wr_data push, clr_ovf clears ovf; full/level/busy/ovf
//   uart_rx_out : registered serial line
// ---------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16,
    parameter int PTR_W        = 4
) (
    input  logic           sysclk,
    input  logic           cpu_resetn,
    uart_tx_ctrl_if.slave  bus,
    output logic           uart_rx_out
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_e          state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               line_q, line_d;
    logic               ovf_q, ovf_d;

    logic               fifo_push;
    logic               fifo_pop;
    logic [7:0]         fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [PTR_W:0]     fifo_level;
    logic               baud_last;

    // Uses the registered full flag, so a same-cycle pop never admits a write
    assign fifo_push = bus.wr_en & ~fifo_full;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk       (sysclk),
        .rst_n     (cpu_resetn),
        .push      (fifo_push),
        .push_data (bus.wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        line_d   = line_q;
        fifo_pop = 1'b0;

        case (state_q)
            ST_IDLE: begin
                line_d = 1'b1;
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    line_d   = 1'b0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    line_d  = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        line_d  = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        // Line is registered, so present the next bit as we shift
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        line_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data waits
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        line_d   = 1'b0;
                        state_d  = ST_START;
                    end else begin
                        line_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                line_d  = 1'b1;
                baud_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // A dropped write in the same cycle as clr_ovf leaves ovf set
    always_comb begin
        ovf_d = ovf_q;
        if (bus.clr_ovf)              ovf_d = 1'b0;
        if (bus.wr_en && fifo_full)   ovf_d = 1'b1;
    end

    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            line_q  <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            line_q  <= line_d;
            ovf_q   <= ovf_d;
        end
    end

    assign uart_rx_out = line_q;
    assign bus.full    = fifo_full;
    assign bus.level   = fifo_level;
    assign bus.busy    = ~fifo_empty | (state_q != ST_IDLE);
    assign bus.ovf     = ovf_q;

endmodule
